if_id_skid_stage: RTL
=====================

Name: if_id_skid_stage

Overview:
Parametrised successor to the IF/ID pipeline register. It adds a valid/ready handshake on both sides and a 2-entry skid buffer, so the fetch side sees a registered ready with no combinational path from ID. It keeps the synchronous flush and the MIPS field decode (R/I/J/FP formats), and adds a saturating stall-cycle counter. It sits between the instruction-fetch stage and the decode stage.

Parameters:
INST_W, 32, instruction width; must be 32 for the field decode.
PC_W, 32, width of PC_4 and PC_ID.
NOP_INST, 32'h0000_0000, instruction value loaded into the entries on reset and flush.
CNT_W, 16, width of Stall_Cnt.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Rst  in  1  asynchronous, active-high reset.
In_Valid  in  1  IF presents PC_4/Inst.
In_Ready  out  1  stage accepts; registered, equals (state != FULL).
PC_4  in  PC_W  PC+4 of the fetched instruction.
Inst  in  INST_W  fetched instruction.
IF_Flush  in  1  synchronous flush; discards all held and incoming instructions.
Out_Valid  out  1  the head entry holds a valid instruction.
Out_Ready  in  1  ID consumes the head entry.
Op_code  out  6  head Inst[31:26].
Rs_ID  out  5  head [25:21].
Rt_ID  out  5  head [20:16].
Rd_ID  out  5  head [15:11].
Shamt_ID  out  5  head [10:6].
Funct_ID  out  6  head [5:0].
Imm16_ID  out  16  head [15:0].
Jmp_Adrs_ID  out  26  head [25:0].
Fmt  out  5  head [25:21].
Fs  out  5  head [15:11].
Fd  out  5  head [10:6].
PC_ID  out  PC_W  head PC_4.
Stall_Cnt  out  CNT_W  count of back-pressure cycles.

Behaviour:
- Storage: head entry {H_pc, H_inst} and skid entry {S_pc, S_inst}. All decode outputs are combinational slices of H_inst; PC_ID = H_pc.
- Handshakes: accept = In_Valid & In_Ready; consume = Out_Valid & Out_Ready.
- State machine, 2-bit: EMPTY, ONE, FULL. Out_Valid = (state != EMPTY). In_Ready = (state != FULL).
- Reset (async, Rst=1):
  - state=EMPTY; H_inst=S_inst=NOP_INST; H_pc=S_pc=0; Stall_Cnt=0.
  - Hence Out_Valid=0, In_Ready=1, all decode fields are slices of NOP_INST (all 0 at default), PC_ID=0.
  - Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- Transitions when IF_Flush=0:
  - EMPTY: accept -> ONE, head <= input; otherwise stay EMPTY.
  - ONE, accept & consume -> ONE, head <= input.
  - ONE, accept & !consume -> FULL, skid <= input, head holds.
  - ONE, !accept & consume -> EMPTY; head contents hold (stale but invalid).
  - ONE, neither -> hold.
  - FULL: consume -> ONE, head <= skid; otherwise hold. No accept is possible (In_Ready=0).
- Latency: an instruction accepted in EMPTY appears on the outputs with Out_Valid=1 on the next edge. Sustained throughput is 1 instruction/cycle with Out_Ready=1.
- Ordering: strict FIFO; the skid entry is never bypassed.
- Flush (IF_Flush=1 at an edge) overrides everything:
  - state <= EMPTY; head and skid inst <= NOP_INST; pcs <= 0.
  - An input offered in the same cycle is dropped. Handshake signals in that cycle still show accept/consume combinationally, but accept has no storage effect.
  - Stall_Cnt does not increment in a flush cycle.
- Stall_Cnt:
  - Increments by 1 on each edge where Out_Valid & !Out_Ready & !IF_Flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by Rst.
- In_Valid/Inst may change while In_Ready=0; the stage samples the input only on accept.
- No X propagation: every register has a reset value.

Test Plan:
1. Reset: Rst=1 for 2 cycles, then release -> Out_Valid=0, In_Ready=1, Op_code=0, PC_ID=0, Stall_Cnt=0. Asserting Rst between edges with state=FULL -> Out_Valid=0 immediately.
2. Pass-through: Out_Ready=1, In_Valid=1, Inst=32'hFC1F07C0, PC_4=32'h4 -> next edge Op_code=6'h3F, Rs_ID=0, Rt_ID=5'h1F, Rd_ID=0, Shamt_ID=5'h1F, Funct_ID=0, Imm16_ID=16'h07C0, Jmp_Adrs_ID=26'h01F07C0, PC_ID=32'h4.
3. Skid fill/drain: Out_Ready=0; send A(PC 8) then B(PC C) -> In_Ready=0 after B; Out_Valid=1 with PC_ID=8. Raise Out_Ready -> PC_ID=8, then C on successive cycles; In_Ready returns to 1 after the first consume.
4. Back-pressure count: hold Out_Valid=1, Out_Ready=0 for 10 cycles -> Stall_Cnt=10. With CNT_W=4, hold for 20 cycles -> Stall_Cnt=15 (saturated).
5. Flush while FULL with In_Valid=1 -> next edge Out_Valid=0, In_Ready=1, Op_code=0; neither held instruction nor the offered one ever appears on the outputs.
6. Random In_Valid/Out_Ready for 1000 cycles against a reference FIFO model -> output sequence equals input sequence; no loss or duplication.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID stage with valid/ready handshakes and a 2-entry skid buffer.
// Decodes MIPS R/I/J/FP fields from the head entry; counts stall cycles.
module if_id_skid_stage #(
  parameter int          INST_W   = 32,
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [PC_W-1:0]   PC_4,
  input  logic [INST_W-1:0] Inst,
  input  logic              IF_Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [5:0]        Op_code,
  output logic [4:0]        Rs_ID,
  output logic [4:0]        Rt_ID,
  output logic [4:0]        Rd_ID,
  output logic [4:0]        Shamt_ID,
  output logic [5:0]        Funct_ID,
  output logic [15:0]       Imm16_ID,
  output logic [25:0]       Jmp_Adrs_ID,
  output logic [4:0]        Fmt,
  output logic [4:0]        Fs,
  output logic [4:0]        Fd,
  output logic [PC_W-1:0]   PC_ID,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [PC_W-1:0]   h_pc, s_pc;
  logic [INST_W-1:0] h_inst, s_inst;

  logic accept, consume;
  logic load_h_in, load_h_skid, load_s;

  assign In_Ready  = (state != FULL);
  assign Out_Valid = (state != EMPTY);
  assign accept    = In_Valid & In_Ready;
  assign consume   = Out_Valid & Out_Ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_n   = ONE;
          load_h_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_h_in = 1'b1;
        end else if (accept) begin
          state_n = FULL;
          load_s  = 1'b1;
        end else if (consume) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_n     = ONE;
          load_h_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    // Flush wins over any handshake in the same cycle
    if (IF_Flush) begin
      state_n     = EMPTY;
      load_h_in   = 1'b0;
      load_h_skid = 1'b0;
      load_s      = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      h_pc   <= '0;
      s_pc   <= '0;
      h_inst <= NOP_INST[INST_W-1:0];
      s_inst <= NOP_INST[INST_W-1:0];
    end else if (IF_Flush) begin
      h_pc   <= '0;
      s_pc   <= '0;
      h_inst <= NOP_INST[INST_W-1:0];
      s_inst <= NOP_INST[INST_W-1:0];
    end else begin
      if (load_h_in) begin
        h_pc   <= PC_4;
        h_inst <= Inst;
      end else if (load_h_skid) begin
        h_pc   <= s_pc;
        h_inst <= s_inst;
      end
      if (load_s) begin
        s_pc   <= PC_4;
        s_inst <= Inst;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Stall_Cnt <= '0;
    end else if (Out_Valid && !Out_Ready && !IF_Flush
                 && (Stall_Cnt != '1)) begin
      Stall_Cnt <= Stall_Cnt + 1'b1;
    end
  end

  assign Op_code     = h_inst[31:26];
  assign Rs_ID       = h_inst[25:21];
  assign Rt_ID       = h_inst[20:16];
  assign Rd_ID       = h_inst[15:11];
  assign Shamt_ID    = h_inst[10:6];
  assign Funct_ID    = h_inst[5:0];
  assign Imm16_ID    = h_inst[15:0];
  assign Jmp_Adrs_ID = h_inst[25:0];
  assign Fmt         = h_inst[25:21];
  assign Fs          = h_inst[15:11];
  assign Fd          = h_inst[10:6];
  assign PC_ID       = h_pc;

endmodule
